yuv420_to_rgb565: RTL and testbench
===================================

Name: yuv420_to_rgb565

Overview:
- Downstream consumer of line_buffer in the jpeg_viewer pipeline.
- Pops raster-order Y/U/V samples from the line buffer read port using o_nempty/i_re.
- Converts each pixel from JFIF full-range YCbCr to RGB565.
- Presents pixels on a valid/ready stream with start-of-frame and end-of-line markers for the LCD output stage.

Parameters:
- COLOR_PRECISION, 8, bits per Y/U/V sample.
- RD_LATENCY, 1, cycles from o_re to valid read data. Use 1 when line_buffer BRAM_OUTPUT_REG="FALSE", 2 when "TRUE".
- OFIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).
- HRES_W, 9, width of i_hres.
- VRES_W, 9, width of i_vres.

Ports:
- r_sysclk  in  1  system clock.
- r_arst  in  1  asynchronous reset, active-high.
- i_hres  in  HRES_W  pixels per line minus 1 (479 for 480 wide).
- i_vres  in  VRES_W  lines per frame minus 1.
- i_nempty  in  1  line buffer has a pixel available.
- o_re  out  1  line buffer read enable.
- i_Y_rd  in  COLOR_PRECISION  luma read data.
- i_U_rd  in  COLOR_PRECISION  Cb read data.
- i_V_rd  in  COLOR_PRECISION  Cr read data.
- o_rgb  out  16  pixel as {R[4:0],G[5:0],B[4:0]}.
- o_valid  out  1  o_rgb valid.
- i_ready  in  1  downstream accepts pixel.
- o_sof  out  1  current o_rgb is pixel (0,0).
- o_eol  out  1  current o_rgb is last pixel of a line.

Behaviour:
- Reset: r_arst asynchronous, active-high; clock r_sysclk. While asserted, all outputs are 0 and the following are cleared: pipeline valids, in-flight counter, FIFO pointers/count, x/y counters.
- Reset mid-frame drops all in-flight and buffered pixels. The first pixel after reset is tagged o_sof.

Read issue (credit-based):
- inflight counts reads issued and not yet written to the FIFO.
- o_re = i_nempty & (inflight + fifo_count < OFIFO_DEPTH). It is combinational from registered counts only and never depends on i_ready.
- A FIFO pop frees its credit on the following cycle, not the same cycle.
- The FIFO therefore never overflows, and no sample is lost while i_ready is low.

Capture:
- Read data is sampled RD_LATENCY cycles after o_re, tracked by a RD_LATENCY-deep valid shift register.

Conversion (3 registered stages, all signed):
- S1: u = U-128, v = V-128 (9-bit signed). Y is zero-extended to 10 bits.
- S2: products, 19-bit accumulation:
  - pr = 359*v
  - pg = 88*u + 183*v
  - pb = 454*u
- S3: with rounding term +128 and arithmetic shift >>>8:
  - R = Y + ((pr+128)>>>8)
  - G = Y - ((pg+128)>>>8)
  - B = Y + ((pb+128)>>>8)
  - Each result is held as 11-bit signed, clamped to 0..255, then truncated: R[7:3], G[7:2], B[7:3].
- S3 output is written to the FIFO together with its sof/eol tags.

Output FIFO:
- Show-ahead; o_valid = fifo not empty.
- Pop on o_valid & i_ready. A write and a pop in the same cycle keep the count unchanged.
- o_rgb, o_sof and o_eol hold stable while o_valid & !i_ready.

Latency:
- With the FIFO empty and i_ready=1, o_valid rises RD_LATENCY+4 cycles after the o_re cycle (RD_LATENCY capture, 3 stages, 1 FIFO).
- Sustained throughput is 1 pixel/cycle when OFIFO_DEPTH ≥ RD_LATENCY+4. Smaller depths throttle throughput through the credit limit.

Position tagging:
- x/y counters advance at S3 write, i.e. in line-buffer order.
- At x == i_hres: eol=1, x wraps to 0, y increments.
- At y == i_vres with eol: y wraps to 0.
- sof = (x==0 && y==0).
- i_hres/i_vres are sampled each pixel. Changes take effect mid-frame without recovery, so software changes them only in reset.

Test Plan:
- Y=0x80,U=0x80,V=0x80 single pixel, i_ready=1 -> o_rgb=0x8410, o_valid 1 cycle, o_valid at RD_LATENCY+4 cycles after o_re.
- Y=0xFF,U=V=0x80 -> 0xFFFF; Y=0x00,U=V=0x80 -> 0x0000; Y=0x80,U=0x80,V=0xFF -> 0xF930 (R clamped at 306→255).
- i_nempty=1 constantly, i_ready=0 for 50 cycles -> exactly OFIFO_DEPTH reads issued; o_re low afterwards; no data lost; release i_ready -> 1 pixel/cycle in issue order.
- i_hres=479, i_vres=15, stream 480*16*2 pixels -> o_eol every 480th handshake, o_sof on pixels 0 and 7680 only.
- Random i_ready (50%) and random i_nempty gaps, scoreboard against golden equations -> zero mismatches, no FIFO overflow/underflow assertions.
- Assert r_arst with 3 pixels buffered -> o_valid/o_re drop asynchronously; after release, the next pixel output carries o_sof=1.

Source files
------------

// File: rtl/yuv420_to_rgb565.sv
// Line-buffer consumer: pops raster-order Y/Cb/Cr samples and converts JFIF full-range YCbCr
// into a valid/ready RGB565 stream, tagging each pixel with start-of-frame and end-of-line.
module yuv420_to_rgb565 #(
  parameter int COLOR_PRECISION = 8,
  parameter int RD_LATENCY      = 1,
  parameter int OFIFO_DEPTH     = 4,
  parameter int HRES_W          = 9,
  parameter int VRES_W          = 9
) (
  input  logic                       r_sysclk,
  input  logic                       r_arst,
  input  logic [HRES_W-1:0]          i_hres,
  input  logic [VRES_W-1:0]          i_vres,
  input  logic                       i_nempty,
  output logic                       o_re,
  input  logic [COLOR_PRECISION-1:0] i_Y_rd,
  input  logic [COLOR_PRECISION-1:0] i_U_rd,
  input  logic [COLOR_PRECISION-1:0] i_V_rd,
  output logic [15:0]                o_rgb,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_sof,
  output logic                       o_eol
);

  localparam int CP = COLOR_PRECISION;
  localparam int PW = CP + 11;
  localparam int SW = CP + 3;
  localparam int AW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic signed [PW-1:0] K_RV  = PW'(359);
  localparam logic signed [PW-1:0] K_GU  = PW'(88);
  localparam logic signed [PW-1:0] K_GV  = PW'(183);
  localparam logic signed [PW-1:0] K_BU  = PW'(454);
  localparam logic signed [PW-1:0] K_RND = PW'(128);
  localparam logic signed [SW-1:0] K_MAX = SW'((1 << CP) - 1);

  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW:0]   w_used;
  logic          w_push;
  logic          w_pop;

  // Credits cover both in-flight reads and FIFO occupancy, so a stalled sink never overflows the FIFO.
  assign w_used = {1'b0, r_inflight} + {1'b0, r_count};
  assign o_re   = ~r_arst & i_nempty & (w_used < (CW+1)'(OFIFO_DEPTH));

  logic [RD_LATENCY-1:0] r_rdv;

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      r_rdv <= '0;
    end else begin
      r_rdv[0] <= o_re;
      for (int i = 1; i < RD_LATENCY; i++) r_rdv[i] <= r_rdv[i-1];
    end
  end

  logic                 r_s1v;
  logic [CP-1:0]        r_y1;
  logic signed [CP:0]   r_u1;
  logic signed [CP:0]   r_v1;
  logic                 r_s2v;
  logic [CP-1:0]        r_y2;
  logic signed [PW-1:0] r_pr;
  logic signed [PW-1:0] r_pg;
  logic signed [PW-1:0] r_pb;
  logic                 r_s3v;
  logic [15:0]          r_rgb;

  logic signed [PW-1:0] w_u1x;
  logic signed [PW-1:0] w_v1x;
  logic signed [SW-1:0] w_y2x;
  logic signed [SW-1:0] w_r;
  logic signed [SW-1:0] w_g;
  logic signed [SW-1:0] w_b;
  logic [CP-1:0]        w_rc;
  logic [CP-1:0]        w_gc;
  logic [CP-1:0]        w_bc;

  function automatic logic [CP-1:0] clampPix(input logic signed [SW-1:0] a);
    if (a < 0)          return '0;
    else if (a > K_MAX) return '1;
    else                return a[CP-1:0];
  endfunction

  assign w_u1x = PW'(r_u1);
  assign w_v1x = PW'(r_v1);
  assign w_y2x = $signed({3'b000, r_y2});
  // Arithmetic shift floors toward minus infinity, which together with +128 gives round-half-up.
  assign w_r   = w_y2x + SW'((r_pr + K_RND) >>> 8);
  assign w_g   = w_y2x - SW'((r_pg + K_RND) >>> 8);
  assign w_b   = w_y2x + SW'((r_pb + K_RND) >>> 8);
  assign w_rc  = clampPix(w_r);
  assign w_gc  = clampPix(w_g);
  assign w_bc  = clampPix(w_b);

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      r_s1v <= 1'b0;
      r_y1  <= '0;
      r_u1  <= '0;
      r_v1  <= '0;
      r_s2v <= 1'b0;
      r_y2  <= '0;
      r_pr  <= '0;
      r_pg  <= '0;
      r_pb  <= '0;
      r_s3v <= 1'b0;
      r_rgb <= '0;
    end else begin
      // Inverting the MSB and sign-extending subtracts the mid-scale offset without an adder.
      r_s1v <= r_rdv[RD_LATENCY-1];
      r_y1  <= i_Y_rd;
      r_u1  <= {~i_U_rd[CP-1], ~i_U_rd[CP-1], i_U_rd[CP-2:0]};
      r_v1  <= {~i_V_rd[CP-1], ~i_V_rd[CP-1], i_V_rd[CP-2:0]};
      r_s2v <= r_s1v;
      r_y2  <= r_y1;
      r_pr  <= K_RV * w_v1x;
      r_pg  <= K_GU * w_u1x + K_GV * w_v1x;
      r_pb  <= K_BU * w_u1x;
      r_s3v <= r_s2v;
      r_rgb <= {5'(w_rc >> (CP-5)), 6'(w_gc >> (CP-6)), 5'(w_bc >> (CP-5))};
    end
  end

  logic [HRES_W-1:0] r_x;
  logic [VRES_W-1:0] r_y;
  logic              w_eol;
  logic              w_sof;

  assign w_eol = (r_x == i_hres);
  assign w_sof = (r_x == '0) && (r_y == '0);

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_s3v) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= (r_y == i_vres) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  logic [17:0] r_mem [OFIFO_DEPTH];
  logic [17:0] w_head;

  assign w_push = r_s3v;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge r_sysclk) begin
    if (w_push) r_mem[r_wptr] <= {w_sof, w_eol, r_rgb};
  end

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({o_re, r_s3v})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign w_head  = r_mem[r_rptr];
  assign o_rgb   = o_valid ? w_head[15:0] : 16'h0000;
  assign o_eol   = o_valid & w_head[16];
  assign o_sof   = o_valid & w_head[17];

endmodule

// File: tb/tb_yuv420_to_rgb565.sv
// Scoreboard bench for yuv420_to_rgb565: a line-buffer model feeds pixels, a reference
// model predicts RGB565 plus sof/eol per issued read, and a monitor checks every handshake.
module tb_yuv420_to_rgb565;

  localparam int CP    = 8;
  localparam int RDL   = 1;
  localparam int DEPTH = 4;
  localparam int HW    = 9;
  localparam int VW    = 9;
  localparam int LAT   = RDL + 4;

  logic          r_sysclk;
  logic          r_arst;
  logic [HW-1:0] i_hres;
  logic [VW-1:0] i_vres;
  logic          i_nempty;
  logic          o_re;
  logic [CP-1:0] i_Y_rd;
  logic [CP-1:0] i_U_rd;
  logic [CP-1:0] i_V_rd;
  logic [15:0]   o_rgb;
  logic          o_valid;
  logic          i_ready;
  logic          o_sof;
  logic          o_eol;

  yuv420_to_rgb565 #(
    .COLOR_PRECISION(CP),
    .RD_LATENCY(RDL),
    .OFIFO_DEPTH(DEPTH),
    .HRES_W(HW),
    .VRES_W(VW)
  ) dut (
    .r_sysclk(r_sysclk),
    .r_arst(r_arst),
    .i_hres(i_hres),
    .i_vres(i_vres),
    .i_nempty(i_nempty),
    .o_re(o_re),
    .i_Y_rd(i_Y_rd),
    .i_U_rd(i_U_rd),
    .i_V_rd(i_V_rd),
    .o_rgb(o_rgb),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sof(o_sof),
    .o_eol(o_eol)
  );

  initial r_sysclk = 1'b0;
  always #5 r_sysclk = ~r_sysclk;

  logic [23:0] srcQ[$];
  logic [17:0] expQ[$];
  logic [15:0] outLog[$];
  int errors = 0;
  int checks = 0;
  int readyPct = 100;
  int gapPct = 0;
  int pixIdx = 0;
  int tbH = 7;
  int tbV = 3;
  int sofSeen = 0;
  int eolSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clamp255(input int a);
    if (a < 0) return 0;
    if (a > 255) return 255;
    return a;
  endfunction

  // Expected output word {sof, eol, rgb565} for the idx-th pixel read since reset.
  function automatic logic [17:0] refPixel(input logic [23:0] p, input int idx);
    int y, u, v, r, g, b, x, row;
    logic [7:0] rc, gc, bc;
    logic sof, eol;
    y   = int'(p[23:16]);
    u   = int'(p[15:8]) - 128;
    v   = int'(p[7:0]) - 128;
    r   = clamp255(y + ((359 * v + 128) >>> 8));
    g   = clamp255(y - ((88 * u + 183 * v + 128) >>> 8));
    b   = clamp255(y + ((454 * u + 128) >>> 8));
    rc  = r[7:0];
    gc  = g[7:0];
    bc  = b[7:0];
    x   = idx % (tbH + 1);
    row = (idx / (tbH + 1)) % (tbV + 1);
    sof = (x == 0) && (row == 0);
    eol = (x == tbH);
    return {sof, eol, rc[7:3], gc[7:2], bc[7:3]};
  endfunction

  task automatic applyStimulus(input logic [23:0] p);
    srcQ.push_back(p);
  endtask

  // Line-buffer model: a read seen at the negedge returns data RDL cycles later.
  initial begin
    logic [23:0] pend;
    bit issued;
    pend = '0;
    forever begin
      @(negedge r_sysclk);
      issued = 1'b0;
      if (o_re === 1'b1) begin
        if (srcQ.size() == 0) begin
          checkOutput("read_from_empty", 32'd1, 32'd0);
        end else begin
          pend = srcQ.pop_front();
          expQ.push_back(refPixel(pend, pixIdx));
          pixIdx++;
          issued = 1'b1;
        end
      end
      @(posedge r_sysclk);
      #1;
      if (issued) {i_Y_rd, i_U_rd, i_V_rd} = pend;
      i_nempty = (srcQ.size() > 0) && ($urandom_range(99) >= gapPct);
      i_ready  = ($urandom_range(99) < readyPct);
    end
  end

  // Monitor: compares each handshake and checks that a stalled output holds steady.
  initial begin
    logic [17:0] heldWord;
    bit holdPending;
    holdPending = 1'b0;
    heldWord = '0;
    forever begin
      @(negedge r_sysclk);
      if (r_arst) begin
        holdPending = 1'b0;
      end else begin
        if (holdPending)
          checkOutput("hold_stable", {o_valid, o_sof, o_eol, o_rgb}, {1'b1, heldWord});
        if (o_valid && i_ready) begin
          if (expQ.size() == 0) checkOutput("unexpected_output", {o_sof, o_eol, o_rgb}, 32'hFFFFFFFF);
          else checkOutput("pixel", {o_sof, o_eol, o_rgb}, expQ.pop_front());
          outLog.push_back(o_rgb);
          if (o_sof) sofSeen++;
          if (o_eol) eolSeen++;
        end
        holdPending = o_valid && !i_ready;
        heldWord = {o_sof, o_eol, o_rgb};
      end
    end
  end

  task automatic doReset(input int h, input int v);
    @(posedge r_sysclk);
    #3;
    r_arst = 1'b1;
    tbH = h;
    tbV = v;
    i_hres = HW'(h);
    i_vres = VW'(v);
    srcQ.delete();
    expQ.delete();
    pixIdx = 0;
    @(negedge r_sysclk);
    checkOutput("reset_outputs", {o_valid, o_re, o_sof, o_eol, o_rgb}, 32'd0);
    @(posedge r_sysclk);
    #3;
    r_arst = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((srcQ.size() != 0 || expQ.size() != 0) && n < limit) begin
      @(negedge r_sysclk);
      n++;
    end
    checkOutput("drain", srcQ.size() + expQ.size(), 32'd0);
  endtask

  task automatic checkLatency();
    int reCyc, vCyc;
    logic [15:0] rgbAt;
    reCyc = -1;
    vCyc = -1;
    rgbAt = '0;
    applyStimulus(24'h808080);
    for (int c = 0; c < 40 && vCyc < 0; c++) begin
      @(negedge r_sysclk);
      if (reCyc < 0 && o_re === 1'b1) reCyc = c;
      else if (reCyc >= 0 && o_valid === 1'b1) begin
        vCyc = c;
        rgbAt = o_rgb;
      end
    end
    checkOutput("latency", vCyc - reCyc, LAT);
    checkOutput("mid_gray", rgbAt, 16'h8410);
    @(negedge r_sysclk);
    checkOutput("single_valid_pulse", o_valid, 1'b0);
  endtask

  task automatic checkCorners();
    outLog.delete();
    applyStimulus(24'hFF8080);
    applyStimulus(24'h008080);
    applyStimulus(24'h8080FF);
    waitDrain(200);
    checkOutput("corner_count", outLog.size(), 3);
    if (outLog.size() == 3) begin
      checkOutput("white", outLog[0], 16'hFFFF);
      checkOutput("black", outLog[1], 16'h0000);
      checkOutput("red_clamp", outLog[2], 16'hF930);
    end
  endtask

  task automatic checkBackpressure();
    int reads, run;
    reads = 0;
    run = 0;
    readyPct = 0;
    for (int i = 0; i < 12; i++) applyStimulus(24'($urandom()));
    repeat (50) begin
      @(negedge r_sysclk);
      if (o_re === 1'b1) reads++;
    end
    checkOutput("stall_reads", reads, DEPTH);
    checkOutput("stall_re_low", o_re, 1'b0);
    checkOutput("stall_valid", o_valid, 1'b1);
    readyPct = 100;
    @(negedge r_sysclk);
    repeat (DEPTH) begin
      if (o_valid === 1'b1 && i_ready === 1'b1) run++;
      @(negedge r_sysclk);
    end
    checkOutput("burst_drain", run, DEPTH);
    waitDrain(500);
  endtask

  task automatic checkMidReset();
    readyPct = 0;
    gapPct = 0;
    for (int i = 0; i < 3; i++) applyStimulus(24'($urandom()));
    repeat (15) @(negedge r_sysclk);
    checkOutput("buffered_valid", o_valid, 1'b1);
    applyStimulus(24'($urandom()));
    @(posedge r_sysclk);
    #2;
    checkOutput("pre_reset_re", o_re, 1'b1);
    #1;
    r_arst = 1'b1;
    srcQ.delete();
    expQ.delete();
    pixIdx = 0;
    #1;
    checkOutput("async_drop", {o_valid, o_re, o_rgb}, 32'd0);
    repeat (2) @(negedge r_sysclk);
    @(posedge r_sysclk);
    #3;
    r_arst = 1'b0;
    readyPct = 100;
    applyStimulus(24'h4080C0);
    for (int c = 0; c < 30 && o_valid !== 1'b1; c++) @(negedge r_sysclk);
    checkOutput("sof_after_reset", {o_valid, o_sof}, 2'b11);
    waitDrain(200);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    r_arst = 1'b1;
    i_hres = HW'(7);
    i_vres = VW'(3);
    i_nempty = 1'b0;
    i_ready = 1'b0;
    i_Y_rd = '0;
    i_U_rd = '0;
    i_V_rd = '0;
    doReset(7, 3);
    readyPct = 100;
    gapPct = 0;
    repeat (3) @(negedge r_sysclk);

    $display("[TB] latency and single pixel");
    checkLatency();
    $display("[TB] corner colours");
    checkCorners();
    $display("[TB] backpressure");
    checkBackpressure();

    $display("[TB] random ready and gaps");
    readyPct = 50;
    gapPct = 30;
    for (int i = 0; i < 400; i++) applyStimulus(24'($urandom()));
    waitDrain(20000);
    readyPct = 100;
    gapPct = 0;

    $display("[TB] reset with pixels buffered");
    checkMidReset();

    $display("[TB] two 480x16 frames");
    doReset(479, 15);
    sofSeen = 0;
    eolSeen = 0;
    for (int i = 0; i < 480 * 16 * 2; i++) applyStimulus(24'($urandom()));
    waitDrain(40000);
    checkOutput("frame_sof_count", sofSeen, 2);
    checkOutput("frame_eol_count", eolSeen, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
